// File: rtl/differentiator.sv
// differentiator
//   Registered first-difference (comb) stage. Every enabled cycle produces
//   the current sample minus the sample taken p_DELAY enabled cycles earlier,
//   wrapped to p_DATA_WIDTH bits. This is the exact inverse of the accumulator.
//   It is used as the comb half of CIC filters and to recover per-sample
//   deltas from running totals.
//
// Parameters
//   p_DATA_WIDTH  width of i_SAMPLE / o_DIFFERENCE
//   p_DELAY       differential delay in enabled samples (1..256)
//
// Ports
//   i_CLK         system clock, rising edge
//   i_RESET_N     asynchronous active-low reset
//   i_CLK_ENABLE  qualifies i_SAMPLE; all state holds when low
//   i_CLEAR       synchronous clear; takes priority over i_CLK_ENABLE
//   i_SAMPLE      signed input sample
//   o_DIFFERENCE  registered i_SAMPLE minus the delayed sample
//   o_VALID       one-cycle pulse when o_DIFFERENCE took an enabled sample
//   o_PRIMED      high once p_DELAY enabled samples have entered
module differentiator #(
    parameter int p_DATA_WIDTH = 8,
    parameter int p_DELAY      = 1
) (
    input  logic                           i_CLK,
    input  logic                           i_RESET_N,
    input  logic                           i_CLK_ENABLE,
    input  logic                           i_CLEAR,
    input  logic signed [p_DATA_WIDTH-1:0] i_SAMPLE,
    output logic signed [p_DATA_WIDTH-1:0] o_DIFFERENCE,
    output logic                           o_VALID,
    output logic                           o_PRIMED
);

    localparam int c_PTR_WIDTH = (p_DELAY > 1) ? $clog2(p_DELAY) : 1;
    localparam logic [c_PTR_WIDTH-1:0] c_LAST = c_PTR_WIDTH'(p_DELAY - 1);

    generate
        if (p_DELAY < 1 || p_DELAY > 256) begin : g_bad_delay
            $error("differentiator: p_DELAY must be within 1..256");
        end
    endgenerate

    typedef enum logic {
        ST_PRIMING,
        ST_RUNNING
    } state_t;

    logic signed [p_DATA_WIDTH-1:0] delay_line [p_DELAY];
    logic [c_PTR_WIDTH-1:0]         wr_ptr;
    logic [c_PTR_WIDTH-1:0]         prime_cnt;
    state_t                         state;

    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            delay_line   <= '{default: '0};
            wr_ptr       <= '0;
            prime_cnt    <= '0;
            state        <= ST_PRIMING;
            o_DIFFERENCE <= '0;
            o_VALID      <= 1'b0;
            o_PRIMED     <= 1'b0;
        end else if (i_CLEAR) begin
            delay_line   <= '{default: '0};
            wr_ptr       <= '0;
            prime_cnt    <= '0;
            state        <= ST_PRIMING;
            o_DIFFERENCE <= '0;
            o_VALID      <= 1'b0;
            o_PRIMED     <= 1'b0;
        end else if (i_CLK_ENABLE) begin
            // The slot under wr_ptr holds the sample from p_DELAY enabled
            // cycles ago (zero while priming); read it, then overwrite it.
            o_DIFFERENCE       <= i_SAMPLE - delay_line[wr_ptr];
            delay_line[wr_ptr] <= i_SAMPLE;
            wr_ptr             <= (wr_ptr == c_LAST) ? '0 : wr_ptr + c_PTR_WIDTH'(1);
            o_VALID            <= 1'b1;
            case (state)
                ST_PRIMING: begin
                    // prime_cnt holds samples already seen; this one is the
                    // p_DELAY-th when the count reaches p_DELAY-1.
                    if (prime_cnt == c_LAST) begin
                        state    <= ST_RUNNING;
                        o_PRIMED <= 1'b1;
                    end else begin
                        prime_cnt <= prime_cnt + c_PTR_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end else begin
            o_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_differentiator.sv
// Bench for differentiator: three instances (p_DELAY = 1, 2, 4) share one
// stimulus stream. The reference model keeps the list of enabled samples
// since the last clear/reset and takes the sample p_DELAY entries back.
module tb_differentiator;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic              clr;
    logic signed [7:0] smp;
    logic signed [7:0] diff   [3];
    logic              valid  [3];
    logic              primed [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        differentiator #(
            .p_DATA_WIDTH(8),
            .p_DELAY((g == 0) ? 1 : (g == 1) ? 2 : 4)
        ) u_dut (
            .i_CLK       (clk),
            .i_RESET_N   (rst_n),
            .i_CLK_ENABLE(en),
            .i_CLEAR     (clr),
            .i_SAMPLE    (smp),
            .o_DIFFERENCE(diff[g]),
            .o_VALID     (valid[g]),
            .o_PRIMED    (primed[g])
        );
    end

    typedef struct packed {
        logic [2:0][7:0] d;
    } exp_t;

    exp_t              expq [$];
    logic signed [7:0] hist [$];
    int                nsamp;
    logic signed [7:0] hold [3];
    logic              exp_valid;
    int                n_checks;
    int                n_err;

    function automatic int dly(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 4;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        hist.delete();
        nsamp = 0;
        for (int k = 0; k < 3; k++) hold[k] = '0;
        exp_valid = 1'b0;
    endtask

    // Drive one cycle's inputs just after the falling edge and record what
    // the following rising edge must produce.
    task automatic step(input logic e, input logic c, input logic signed [7:0] s);
        exp_t it;
        logic signed [7:0] past;
        @(negedge clk);
        #1;
        en  = e;
        clr = c;
        smp = s;
        if (c) begin
            model_clear();
        end else if (e) begin
            for (int k = 0; k < 3; k++) begin
                past    = (hist.size() >= dly(k)) ? hist[hist.size() - dly(k)] : 8'sd0;
                hold[k] = s - past;
                it.d[k] = hold[k];
            end
            expq.push_back(it);
            hist.push_back(s);
            if (hist.size() > 4) void'(hist.pop_front());
            nsamp++;
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        #1;
        en    = 1'b0;
        clr   = 1'b0;
        rst_n = 1'b0;
        model_clear();
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("async_rst_diff",   int'(diff[k]),   0);
            chk("async_rst_valid",  int'(valid[k]),  0);
            chk("async_rst_primed", int'(primed[k]), 0);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard on every presented output, checks holds
    // and priming on every cycle.
    always @(negedge clk) begin
        exp_t it;
        if (valid[0]) begin
            if (expq.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                it = expq.pop_front();
                for (int k = 0; k < 3; k++)
                    chk($sformatf("diff_d%0d", dly(k)), int'(diff[k]), int'($signed(it.d[k])));
            end
        end else begin
            for (int k = 0; k < 3; k++)
                chk($sformatf("hold_d%0d", dly(k)), int'(diff[k]), int'(hold[k]));
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("valid_d%0d", dly(k)),  int'(valid[k]),  int'(exp_valid));
            chk($sformatf("primed_d%0d", dly(k)), int'(primed[k]), (nsamp >= dly(k)) ? 1 : 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic signed [7:0] acc;
        logic signed [7:0] s;
        int unsigned r;
        n_checks = 0;
        n_err    = 0;
        model_clear();
        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        smp   = '0;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;

        // basic differences
        step(1, 0, 8'sd10);
        step(1, 0, 8'sd30);
        step(1, 0, 8'sd25);
        step(1, 0, 8'sd25);

        // wrap: 127 then -128
        step(0, 1, 8'sd0);
        step(1, 0, 8'sd127);
        step(1, 0, -8'sd128);

        // accumulator chain must be reproduced despite wrap
        step(0, 1, 8'sd0);
        acc = '0;
        foreach (hist[i]) ;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: s = 8'sd3;
                1: s = -8'sd7;
                default: s = 8'sd100;
            endcase
            acc = acc + s;
            step(1, 0, acc);
        end

        // ramp 1..8
        step(0, 1, 8'sd0);
        for (int i = 1; i <= 8; i++) step(1, 0, 8'(i));

        // enable gating: 99 never captured
        step(0, 1, 8'sd0);
        step(1, 0, 8'sd5);
        repeat (3) step(0, 0, 8'sd99);
        step(1, 0, 8'sd8);

        // clear with simultaneous enabled sample
        step(0, 1, 8'sd0);
        step(1, 0, 8'sd4);
        step(1, 0, 8'sd9);
        step(1, 1, 8'sd50);
        step(1, 0, 8'sd6);

        // async reset mid-stream
        step(1, 0, 8'sd11);
        step(1, 0, 8'sd22);
        step(1, 0, 8'sd33);
        async_reset();
        step(1, 0, 8'sd7);
        step(0, 0, 8'sd0);

        // randomized traffic with boundary values mixed in
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            case ($urandom_range(0, 5))
                0: s = 8'sd127;
                1: s = -8'sd128;
                default: s = 8'($urandom);
            endcase
            step(($urandom_range(0, 3) != 0), (r < 3), s);
        end

        repeat (3) step(0, 0, 8'sd0);
        @(negedge clk);
        #1;
        chk("scoreboard_empty", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/differentiator.md
Name: differentiator

Overview:
- Registered first-difference (comb) stage: each enabled cycle outputs the current sample minus the sample taken p_DELAY enabled cycles earlier.
- Exact inverse of the team's accumulator. Feeding accumulator output into this block (matching width, p_DELAY=1) reproduces the original summand stream, including across two's-complement wrap.
- Used as the comb half of CIC decimators/interpolators and for recovering per-sample deltas from running totals.

Parameters:
- p_DATA_WIDTH, 8, bit width of i_SAMPLE and o_DIFFERENCE.
- p_DELAY, 1, differential delay in enabled samples. Legal range 1..256; out of range must fail elaboration.

Ports:
- i_CLK  input  1  system clock; all state updates on the rising edge.
- i_RESET_N  input  1  asynchronous, active-low reset; clears all state immediately on assertion.
- i_CLK_ENABLE  input  1  active high; qualifies i_SAMPLE. When low, all state holds.
- i_CLEAR  input  1  synchronous, active high; zeroes the delay line, output and priming state.
- i_SAMPLE  input  p_DATA_WIDTH  signed incoming sample.
- o_DIFFERENCE  output  p_DATA_WIDTH  signed, registered: i_SAMPLE minus the delayed sample.
- o_VALID  output  1  registered; one-cycle pulse when o_DIFFERENCE was updated by an enabled sample.
- o_PRIMED  output  1  registered; high once p_DELAY enabled samples have entered since reset or clear.

Behaviour:
- Storage: circular delay line of p_DELAY words with a write pointer of width max(1, clog2(p_DELAY)).
  - Pointer wraps from p_DELAY-1 to 0.
  - For p_DELAY=1 the delay line degenerates to a single register.
- Reset (i_RESET_N low, asynchronous): o_DIFFERENCE=0, o_VALID=0, o_PRIMED=0, all delay words=0, pointer=0, prime counter=0. Outputs stay at these values while reset is held. First update is on the first rising edge after deassertion.
- Priority per edge: i_CLEAR, then i_CLK_ENABLE, then hold.
- i_CLEAR=1: same values as reset, applied synchronously. Any simultaneous enabled sample is discarded.
- i_CLK_ENABLE=1, i_CLEAR=0:
  - o_DIFFERENCE <= i_SAMPLE - line[ptr], modulo 2^p_DATA_WIDTH (wrap, no saturation, no widening).
  - line[ptr] <= i_SAMPLE.
  - ptr advances.
  - o_VALID <= 1.
- i_CLK_ENABLE=0: o_DIFFERENCE, line, ptr and prime counter hold; o_VALID <= 0.
- Latency: one clock from an enabled sample to o_DIFFERENCE / o_VALID.
- Priming state machine:
  - PRIMING: counter counts enabled samples. On the p_DELAY-th enabled sample, move to RUNNING; o_PRIMED rises on that same edge.
  - RUNNING: o_PRIMED=1; counter frozen. Leaves only on i_CLEAR or reset.
  - Outputs during PRIMING are still computed, against zeroed history (sample minus 0), so the output is defined.
- Wrap rule: result is the low p_DATA_WIDTH bits of the two's-complement subtraction, e.g. W=8: -128 - 127 = +1.
- No combinational path from any input to any output.

Test Plan:
- W=8, D=1, after reset: enable held high, samples 10, 30, 25, 25 -> o_DIFFERENCE 10, 20, -5, 0 on the following edges; o_VALID high each cycle; o_PRIMED high from the first enabled edge.
- W=8, D=1, wrap: samples 127 then -128 -> outputs 127 then +1. Also drive from an accumulator chain with summands 3, -7, 100, 100 -> outputs reproduce 3, -7, 100, 100 exactly despite the accumulator wrapping.
- W=8, D=4:
  - samples 1..8 -> outputs 1, 2, 3, 4, 4, 4, 4, 4.
  - o_PRIMED low through the 3rd sample; rises on the edge registering the 4th sample.
- Enable gating, D=1: samples 5 (en), 99 (en=0, 3 cycles), 8 (en):
  - outputs 5, held at 5 with o_VALID=0 for 3 cycles, then 3.
  - 99 is never captured.
- Clear with simultaneous enable, D=2, after samples 4, 9: i_CLEAR=1 with i_CLK_ENABLE=1 and sample 50 -> next edge o_DIFFERENCE=0, o_VALID=0, o_PRIMED=0. Then sample 6 -> 6.
- Async reset mid-stream, D=2 running: drop i_RESET_N between edges -> outputs 0 immediately without a clock edge. After release, sample 7 -> o_DIFFERENCE=7, o_PRIMED=0.
